// File: rtl/tmr32_pkg.sv
// Shared definitions for the TMR32 PWM step sequencer: state encoding,
// default sizing and the step record layout.
package tmr32_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_RPT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]          cmp;
        logic [DEF_RPT_W-1:0] rpt;
    } step_t;

endpackage

// File: rtl/tmr32_seq_tbl.sv
// Step table register file: one synchronous write port, one asynchronous
// read port, every entry cleared by reset.
module tmr32_seq_tbl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: this is a flop array, not a RAM macro, so it can and must be
    // reset; a cleared table makes a start after reset deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tmr32_pwm_seq.sv
// Walks a TMR32 timer in periodic PWM mode through a table of
// {compare, repeat} steps, acknowledging one OVF flag per period.
module tmr32_pwm_seq
    import tmr32_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int RPT_W = DEF_RPT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [31:0]      wr_cmp,
    input  logic [RPT_W-1:0] wr_rpt,
    input  logic [AW:0]      seq_len,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             tmr_ovf,
    output logic             tmr_en,
    output logic [31:0]      tmr_cmp,
    output logic             tmr_ovf_clr,
    output logic             busy,
    output logic [AW-1:0]    cur_step,
    output logic             done
);

    localparam int W = 32 + RPT_W;

    state_t           state;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] cur_rpt;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_data;
    logic [31:0]      rd_cmp;
    logic [RPT_W-1:0] rd_rpt;
    logic [AW+1:0]    step_p1;
    logic             is_last;
    logic             seq_ok;
    logic [AW-1:0]    next_step;

    tmr32_seq_tbl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W)
    ) u_tbl (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_cmp, wr_rpt}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_cmp = rd_data[W-1:RPT_W];
    assign rd_rpt = rd_data[RPT_W-1:0];

    // Comparing cur_step+1 against seq_len also treats a live seq_len of 0
    // (or one shrunk below cur_step) as "on the last step".
    assign step_p1   = {2'b00, cur_step} + (AW+2)'(1);
    assign is_last   = step_p1 >= {1'b0, seq_len};
    assign next_step = is_last ? '0 : cur_step + AW'(1);
    assign rd_addr   = (state == S_IDLE) ? '0 : next_step;
    assign seq_ok    = (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
    assign busy      = (state != S_IDLE);

    // The repeat limit is latched at step load, so rewriting the active
    // entry only matters the next time that entry is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tmr_en      <= 1'b0;
            tmr_cmp     <= '0;
            tmr_ovf_clr <= 1'b0;
            cur_step    <= '0;
            done        <= 1'b0;
            rpt_cnt     <= '0;
            cur_rpt     <= '0;
        end else begin
            tmr_ovf_clr <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                tmr_en <= 1'b0;
                state  <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && seq_ok) begin
                            tmr_cmp  <= rd_cmp;
                            cur_rpt  <= rd_rpt;
                            tmr_en   <= 1'b1;
                            cur_step <= '0;
                            rpt_cnt  <= '0;
                            state    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (tmr_ovf) begin
                            tmr_ovf_clr <= 1'b1;
                            state       <= S_ACK;
                            if (rpt_cnt < cur_rpt) begin
                                rpt_cnt <= rpt_cnt + RPT_W'(1);
                            end else begin
                                rpt_cnt <= '0;
                                if (is_last && !loop) begin
                                    tmr_en <= 1'b0;
                                    done   <= 1'b1;
                                    state  <= S_IDLE;
                                end else begin
                                    cur_step <= next_step;
                                    tmr_cmp  <= rd_cmp;
                                    cur_rpt  <= rd_rpt;
                                end
                            end
                        end
                    end
                    S_ACK: begin
                        if (!tmr_ovf) state <= S_RUN;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmr32_pwm_seq.sv
// Self-checking bench for tmr32_pwm_seq: table-driven OVF sequences with a
// scoreboard of expected post-acknowledge outputs, plus corner-case sequences.
module tb_tmr32_pwm_seq;
    import tmr32_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RPT_W = 8;

    typedef struct {
        logic [AW-1:0] step;
        logic [31:0]   cmp;
        logic          done;
        logic          en;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [31:0]      wr_cmp = '0;
    logic [RPT_W-1:0] wr_rpt = '0;
    logic [AW:0]      seq_len = '0;
    logic             loop = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             tmr_ovf = 1'b0;
    logic             tmr_en;
    logic [31:0]      tmr_cmp;
    logic             tmr_ovf_clr;
    logic             busy;
    logic [AW-1:0]    cur_step;
    logic             done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    tmr32_pwm_seq #(.DEPTH(DEPTH), .AW(AW), .RPT_W(RPT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_cmp      (wr_cmp),
        .wr_rpt      (wr_rpt),
        .seq_len     (seq_len),
        .loop        (loop),
        .start       (start),
        .stop        (stop),
        .tmr_ovf     (tmr_ovf),
        .tmr_en      (tmr_en),
        .tmr_cmp     (tmr_cmp),
        .tmr_ovf_clr (tmr_ovf_clr),
        .busy        (busy),
        .cur_step    (cur_step),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_step(input int addr, input logic [31:0] cmp, input logic [RPT_W-1:0] rpt);
        step_t s;
        s.cmp   = cmp;
        s.rpt   = rpt;
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_cmp  = s.cmp;
        wr_rpt  = s.rpt;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int len, input logic lp);
        seq_len = (AW+1)'(len);
        loop    = lp;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Raise OVF, wait (bounded) for the clear pulse, compare against the
    // scoreboard head, optionally keep the flag sticky, then drop it.
    task automatic do_ovf(input exp_t e, input int hold);
        exp_t got;
        bit   seen = 0;
        int   extra = 0;
        sb.push_back(e);
        tmr_ovf = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (tmr_ovf_clr) seen = 1;
        end
        if (!seen) begin
            check("ovf_clr_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            check("ovf_cmp",  tmr_cmp,  got.cmp);
            check("ovf_step", 32'(cur_step), 32'(got.step));
            check("ovf_done", 32'(done),   32'(got.done));
            check("ovf_en",   32'(tmr_en), 32'(got.en));
            for (int i = 0; i < hold; i++) begin
                tick();
                if (tmr_ovf_clr) extra++;
                check("sticky_busy", 32'(busy), 32'd1);
            end
            if (hold > 0) check("sticky_clr_pulses", 32'(extra), 32'd0);
        end
        tmr_ovf = 1'b0;
        tick();
        check("post_clr_low",  32'(tmr_ovf_clr), 32'd0);
        check("post_done_low", 32'(done), 32'd0);
    endtask

    function automatic exp_t mk(input int step, input int cmp, input bit dn, input bit en);
        exp_t e;
        e.step = AW'(step);
        e.cmp  = 32'(cmp);
        e.done = dn;
        e.en   = en;
        return e;
    endfunction

    initial begin
        exp_t multi_v[4];
        exp_t loop_v[8];

        multi_v[0] = mk(1, 20, 0, 1);
        multi_v[1] = mk(1, 20, 0, 1);
        multi_v[2] = mk(2, 30, 0, 1);
        multi_v[3] = mk(2, 30, 1, 0);
        for (int i = 0; i < 8; i++) begin
            loop_v[i] = (i % 4 == 3) ? mk(0, 10, 0, 1)
                      : (i % 4 == 2) ? mk(2, 30, 0, 1) : mk(1, 20, 0, 1);
        end

        tick();
        check("rst_en",   32'(tmr_en), 32'd0);
        check("rst_cmp",  tmr_cmp, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single step, no loop: three periods, done on the third.
        write_step(0, 32'd5, 8'd2);
        do_start(1, 1'b0);
        check("s1_en",  32'(tmr_en), 32'd1);
        check("s1_cmp", tmr_cmp, 32'd5);
        do_ovf(mk(0, 5, 0, 1), 0);
        do_ovf(mk(0, 5, 0, 1), 0);
        do_ovf(mk(0, 5, 1, 0), 0);
        check("s1_busy_end", 32'(busy), 32'd0);
        check("s1_en_end",   32'(tmr_en), 32'd0);

        // Multi-step advance.
        write_step(0, 32'd10, 8'd0);
        write_step(1, 32'd20, 8'd1);
        write_step(2, 32'd30, 8'd0);
        do_start(3, 1'b0);
        check("ms_cmp0",  tmr_cmp, 32'd10);
        check("ms_step0", 32'(cur_step), 32'd0);
        for (int i = 0; i < 4; i++) do_ovf(multi_v[i], 0);
        check("ms_busy_end", 32'(busy), 32'd0);

        // Loop wrap: eight periods, never done, always busy.
        do_start(3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            do_ovf(loop_v[i], 0);
            check("loop_busy", 32'(busy), 32'd1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'd0);
        check("loop_stop_cmp",  tmr_cmp, 32'd10);

        // Sticky flag: held 4 extra cycles, counted once (rpt=3 -> 4 periods).
        write_step(0, 32'd7, 8'd3);
        do_start(1, 1'b0);
        do_ovf(mk(0, 7, 0, 1), 4);
        do_ovf(mk(0, 7, 0, 1), 0);
        do_ovf(mk(0, 7, 0, 1), 0);
        do_ovf(mk(0, 7, 1, 0), 0);

        // Stop collides with OVF on the last step.
        write_step(0, 32'd5, 8'd0);
        do_start(1, 1'b0);
        tmr_ovf = 1'b1;
        stop    = 1'b1;
        tick();
        tmr_ovf = 1'b0;
        stop    = 1'b0;
        check("stop_en",   32'(tmr_en), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        check("stop_clr",  32'(tmr_ovf_clr), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_cmp",  tmr_cmp, 32'd5);

        // Start while busy is ignored; stop beats start.
        do_start(1, 1'b1);
        write_step(0, 32'd9, 8'd0);
        do_start(1, 1'b1);
        check("busy_start_cmp", tmr_cmp, 32'd5);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        check("stop_over_start", 32'(busy), 32'd0);

        // Repeat count all-ones: 256 periods before done.
        write_step(0, 32'd99, 8'hFF);
        do_start(1, 1'b0);
        for (int i = 0; i < 256; i++) do_ovf(mk(0, 99, i == 255, i != 255), 0);

        // Bad starts: seq_len 0 and DEPTH+1.
        do_start(0, 1'b0);
        tick();
        check("bad0_en",   32'(tmr_en), 32'd0);
        check("bad0_busy", 32'(busy), 32'd0);
        do_start(DEPTH + 1, 1'b0);
        tick();
        check("bad9_en", 32'(tmr_en), 32'd0);

        // Async reset mid-run clears outputs and the whole table.
        for (int i = 0; i < DEPTH; i++) write_step(i, 32'(100 + i), 8'd1);
        do_start(DEPTH, 1'b1);
        do_ovf(mk(0, 100, 0, 1), 0);
        do_ovf(mk(1, 101, 0, 1), 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en",   32'(tmr_en), 32'd0);
        check("arst_cmp",  tmr_cmp, 32'd0);
        check("arst_step", 32'(cur_step), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_clr",  32'(tmr_ovf_clr), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(DEPTH, 1'b0);
        check("tbl0_cmp", tmr_cmp, 32'd0);
        for (int i = 1; i < DEPTH; i++) do_ovf(mk(i, 0, 0, 1), 0);
        do_ovf(mk(DEPTH - 1, 0, 1, 0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
